// File: rtl/pool_layer_v2.sv
// Streaming non-overlapping 2-D max/average pooling over a lane-packed blob stream.
// Partial window results live in a per-output-column row accumulator.
module pool_layer_v2 #(
  parameter int DIN_W = 16,
  parameter int LANES = 8,
  parameter int W_IN  = 16,
  parameter int H_IN  = 16,
  parameter int C_IN  = 32,
  parameter int POOL  = 2,
  parameter int RELU  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode_avg,
  input  logic                   blob_din_en,
  output logic                   blob_din_rdy,
  input  logic [LANES*DIN_W-1:0] blob_din,
  input  logic                   blob_din_eop,
  output logic                   blob_dout_en,
  input  logic                   blob_dout_rdy,
  output logic [LANES*DIN_W-1:0] blob_dout,
  output logic                   blob_dout_eop,
  output logic                   err_eop
);

  localparam int CG    = C_IN / LANES;
  localparam int PL    = (POOL == 4) ? 2 : 1;
  localparam int SH    = 2 * PL;
  localparam int ACC_W = DIN_W + SH;
  localparam int W_OUT = W_IN / POOL;
  localparam int H_OUT = H_IN / POOL;
  localparam int DEPTH = W_OUT * CG;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (CG > 1) ? $clog2(CG) : 1;
  localparam int XW    = $clog2(W_IN + 1);
  localparam int YW    = $clog2(H_IN + 1);

  localparam logic [CW-1:0] CG_LAST = CW'(CG - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(W_IN - 1);
  localparam logic [XW-1:0] X_LIM   = XW'(W_OUT * POOL);
  localparam logic [XW-1:0] OX_LAST = XW'(W_OUT - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(H_IN - 1);
  localparam logic [YW-1:0] Y_LIM   = YW'(H_OUT * POOL);
  localparam logic [YW-1:0] OY_LAST = YW'(H_OUT - 1);

  logic [CW-1:0] cg;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          mode_r;

  logic [LANES*ACC_W-1:0] acc_mem [DEPTH];
  logic [LANES*ACC_W-1:0] rd;
  logic [LANES*ACC_W-1:0] nxt;
  logic [LANES*DIN_W-1:0] res;
  logic [AW-1:0]          addr;

  logic accept;
  logic frame_start;
  logic cur_avg;
  logic in_rng;
  logic win_first;
  logic win_last;
  logic out_last;
  logic beat_last;

  assign blob_din_rdy = !rst && (!blob_dout_en || blob_dout_rdy);
  assign accept       = blob_din_en && blob_din_rdy;

  assign frame_start = (cg == '0) && (x == '0) && (y == '0);
  assign cur_avg     = frame_start ? mode_avg : mode_r;
  assign in_rng      = (x < X_LIM) && (y < Y_LIM);
  assign win_first   = (x[PL-1:0] == '0) && (y[PL-1:0] == '0);
  assign win_last    = (&x[PL-1:0]) && (&y[PL-1:0]);
  assign beat_last   = (cg == CG_LAST) && (x == X_LAST)
                    && (y == Y_LAST);
  assign out_last    = (cg == CG_LAST) && ((x >> PL) == OX_LAST)
                    && ((y >> PL) == OY_LAST);

  assign addr = AW'(x >> PL) * AW'(CG) + AW'(cg);
  assign rd   = acc_mem[addr];

  logic signed [ACC_W-1:0] d_l;
  logic signed [ACC_W-1:0] a_l;
  logic signed [ACC_W-1:0] n_l;
  logic signed [DIN_W-1:0] r_l;

  always_comb begin
    nxt = '0;
    res = '0;
    d_l = '0;
    a_l = '0;
    n_l = '0;
    r_l = '0;
    for (int i = 0; i < LANES; i++) begin
      d_l = {{SH{blob_din[i*DIN_W+DIN_W-1]}},
             blob_din[i*DIN_W +: DIN_W]};
      a_l = rd[i*ACC_W +: ACC_W];
      if (win_first)
        n_l = d_l;
      else if (cur_avg)
        n_l = a_l + d_l;
      else if ($signed(a_l[DIN_W-1:0]) > $signed(d_l[DIN_W-1:0]))
        n_l = a_l;
      else
        n_l = d_l;
      nxt[i*ACC_W +: ACC_W] = n_l;
      // floor division by the window area via arithmetic shift
      r_l = cur_avg ? DIN_W'(n_l >>> SH) : DIN_W'(n_l);
      if (RELU != 0 && r_l < 0)
        r_l = '0;
      res[i*DIN_W +: DIN_W] = r_l;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && in_rng)
      acc_mem[addr] <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cg            <= '0;
      x             <= '0;
      y             <= '0;
      mode_r        <= 1'b0;
      err_eop       <= 1'b0;
      blob_dout_en  <= 1'b0;
      blob_dout     <= '0;
      blob_dout_eop <= 1'b0;
    end else begin
      if (accept) begin
        if (frame_start)
          mode_r <= mode_avg;
        if (blob_din_eop && !beat_last) begin
          err_eop <= 1'b1;
          cg      <= '0;
          x       <= '0;
          y       <= '0;
        end else begin
          if (beat_last && !blob_din_eop)
            err_eop <= 1'b1;
          if (cg == CG_LAST) begin
            cg <= '0;
            if (x == X_LAST) begin
              x <= '0;
              y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end else begin
            cg <= cg + 1'b1;
          end
        end
      end
      if (accept && in_rng && win_last) begin
        blob_dout_en  <= 1'b1;
        blob_dout     <= res;
        blob_dout_eop <= out_last;
      end else if (blob_dout_rdy) begin
        blob_dout_en  <= 1'b0;
        blob_dout_eop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_layer_v2.sv
// Directed bench for pool_layer_v2: a default 16x16x32 instance and a
// 5x5x8 ReLU instance, both checked against a window-level reference model.
module tb_pool_layer_v2;

  localparam int BW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          mode_a, en_a, rdy_a, eop_in_a;
  logic          oen_a, ordy_a, oeop_a, err_a;
  logic [BW-1:0] din_a, dout_a;

  logic          mode_b, en_b, rdy_b, eop_in_b;
  logic          oen_b, ordy_b, oeop_b, err_b;
  logic [BW-1:0] din_b, dout_b;

  pool_layer_v2 u_a (
    .clk           (clk),
    .rst           (rst),
    .mode_avg      (mode_a),
    .blob_din_en   (en_a),
    .blob_din_rdy  (rdy_a),
    .blob_din      (din_a),
    .blob_din_eop  (eop_in_a),
    .blob_dout_en  (oen_a),
    .blob_dout_rdy (ordy_a),
    .blob_dout     (dout_a),
    .blob_dout_eop (oeop_a),
    .err_eop       (err_a)
  );

  pool_layer_v2 #(
    .W_IN (5),
    .H_IN (5),
    .C_IN (8),
    .RELU (1)
  ) u_b (
    .clk           (clk),
    .rst           (rst),
    .mode_avg      (mode_b),
    .blob_din_en   (en_b),
    .blob_din_rdy  (rdy_b),
    .blob_din      (din_b),
    .blob_din_eop  (eop_in_b),
    .blob_dout_en  (oen_b),
    .blob_dout_rdy (ordy_b),
    .blob_dout     (dout_b),
    .blob_dout_eop (oeop_b),
    .err_eop       (err_b)
  );

  int errors = 0;
  int checks = 0;
  int fa[];
  int fb[];
  logic [BW:0] exp_a[$];
  logic [BW:0] exp_b[$];
  logic bp_go = 1'b0;

  function automatic int px(int which, int idx);
    return (which != 0) ? fb[idx] : fa[idx];
  endfunction

  function automatic int floor_div(int s, int n);
    int q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(string name, logic [BW:0] got, logic [BW:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic finish_now();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // kind 0: ramp x+y*16, 1: small random, 2: wide random
  task automatic fill(int which, int W, int H, int C, int kind);
    int v;
    if (which != 0) fb = new[W*H*C];
    else fa = new[W*H*C];
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < C; c++) begin
          if (kind == 0) v = x + y * 16;
          else if (kind == 1) v = $urandom_range(0, 2000) - 1000;
          else v = $urandom_range(0, 40000) - 20000;
          if (which != 0) fb[(y*W+x)*C+c] = v;
          else fa[(y*W+x)*C+c] = v;
        end
  endtask

  task automatic setpx(int which, int W, int C, int x, int y, int c, int v);
    if (which != 0) fb[(y*W+x)*C+c] = v;
    else fa[(y*W+x)*C+c] = v;
  endtask

  // Expected outputs whose window closes within the first nbeats beats
  task automatic gen(int which, int W, int H, int C, int P,
                     int relu, int avg, int nbeats);
    int cgn, wo, ho, done, s, mx, v, r;
    logic [BW:0] e;
    cgn = C / 8;
    wo = W / P;
    ho = H / P;
    for (int oy = 0; oy < ho; oy++)
      for (int ox = 0; ox < wo; ox++)
        for (int g = 0; g < cgn; g++) begin
          done = ((oy*P+P-1)*W + ox*P+P-1)*cgn + g;
          if (done < nbeats) begin
            e = '0;
            for (int l = 0; l < 8; l++) begin
              s = 0;
              mx = -100000;
              for (int dy = 0; dy < P; dy++)
                for (int dx = 0; dx < P; dx++) begin
                  v = px(which, ((oy*P+dy)*W + ox*P+dx)*C + g*8+l);
                  s += v;
                  if (v > mx) mx = v;
                end
              r = (avg != 0) ? floor_div(s, P*P) : mx;
              if (relu != 0 && r < 0) r = 0;
              e[l*16 +: 16] = 16'(r);
            end
            e[BW] = (oy == ho-1) && (ox == wo-1) && (g == cgn-1);
            if (which != 0) exp_b.push_back(e);
            else exp_a.push_back(e);
          end
        end
  endtask

  task automatic send(int which, int W, int C, logic mode0,
                      int toggle_at, int eop_at, int nbeats);
    int cgn, g, x, y, to;
    logic [BW-1:0] d;
    logic m, e;
    cgn = C / 8;
    for (int b = 0; b < nbeats; b++) begin
      g = b % cgn;
      x = (b / cgn) % W;
      y = b / (cgn * W);
      d = '0;
      for (int l = 0; l < 8; l++)
        d[l*16 +: 16] = 16'(px(which, (y*W+x)*C + g*8+l));
      m = (toggle_at >= 0 && b >= toggle_at) ? !mode0 : mode0;
      e = (b == eop_at);
      @(negedge clk);
      if (which != 0) begin
        en_b = 1'b1; din_b = d; eop_in_b = e; mode_b = m;
      end else begin
        en_a = 1'b1; din_a = d; eop_in_a = e; mode_a = m;
      end
      #1;
      to = 0;
      while (!((which != 0) ? rdy_b : rdy_a)) begin
        @(negedge clk);
        #1;
        to++;
        if (to > 2000) begin
          errors++;
          checks++;
          $display("FAIL din_rdy_timeout beat=%0d got=0 want=1", b);
          finish_now();
        end
      end
      @(posedge clk);
    end
    @(negedge clk);
    if (which != 0) begin
      en_b = 1'b0; eop_in_b = 1'b0;
    end else begin
      en_a = 1'b0; eop_in_a = 1'b0;
    end
  endtask

  task automatic drain(int which);
    int to, n;
    to = 0;
    n = (which != 0) ? exp_b.size() : exp_a.size();
    while (n != 0 && to < 500) begin
      @(negedge clk);
      to++;
      n = (which != 0) ? exp_b.size() : exp_a.size();
    end
    chk("drain_left", n, 0);
  endtask

  // Output compare: one sample per cycle, clear of both clock edges
  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [BW:0] held_a, held_b, ew;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (stall_a) chk("hold_a", {oen_a, oeop_a, dout_a}, {1'b1, held_a});
      if (oen_a && ordy_a) begin
        stall_a = 1'b0;
        if (exp_a.size() == 0) begin
          chk("extra_a", {oeop_a, dout_a}, 'x);
        end else begin
          ew = exp_a.pop_front();
          chk("beat_a", {oeop_a, dout_a}, ew);
        end
      end else if (oen_a) begin
        stall_a = 1'b1;
        held_a = {oeop_a, dout_a};
      end else begin
        stall_a = 1'b0;
      end
      if (stall_b) chk("hold_b", {oen_b, oeop_b, dout_b}, {1'b1, held_b});
      if (oen_b && ordy_b) begin
        stall_b = 1'b0;
        if (exp_b.size() == 0) begin
          chk("extra_b", {oeop_b, dout_b}, 'x);
        end else begin
          ew = exp_b.pop_front();
          chk("beat_b", {oeop_b, dout_b}, ew);
        end
      end else if (oen_b) begin
        stall_b = 1'b1;
        held_b = {oeop_b, dout_b};
      end else begin
        stall_b = 1'b0;
      end
    end
  end

  // Hold the first output of frame 1 for 10 cycles
  initial begin
    int to;
    ordy_a = 1'b1;
    ordy_b = 1'b1;
    wait (bp_go);
    to = 0;
    while (to < 5000) begin
      @(negedge clk);
      if (oen_a) break;
      to++;
    end
    chk("bp_first_out", oen_a, 1);
    ordy_a = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("bp_din_rdy", rdy_a, 0);
    end
    @(negedge clk);
    ordy_a = 1'b1;
  end

  initial begin
    logic [BW:0] t;
    rst = 1'b1;
    mode_a = 0; en_a = 0; eop_in_a = 0; din_a = '0;
    mode_b = 0; en_b = 0; eop_in_b = 0; din_b = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dout_en", oen_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_dout_eop", oeop_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_din_rdy", rdy_a, 0);
    chk("rst_din_rdy_b", rdy_b, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_din_rdy", rdy_a, 1);

    // Frame 1: ramp, max mode, with backpressure on the first output
    fill(0, 16, 16, 32, 0);
    gen(0, 16, 16, 32, 2, 0, 0, 1024);
    chk("model_cnt", exp_a.size(), 256);
    t = exp_a[0];
    chk("model_ramp0", t[15:0], 17);
    t = exp_a[255];
    chk("model_ramp255", {t[BW], t[127:112]}, {1'b1, 16'd255});
    t = exp_a[254];
    chk("model_eop254", t[BW], 0);
    bp_go = 1'b1;
    send(0, 16, 32, 1'b0, -1, 1023, 1024);
    drain(0);
    chk("err_f1", err_a, 0);

    // Frame 2: average mode, mode input flips mid-frame
    fill(0, 16, 16, 32, 1);
    setpx(0, 16, 32, 0, 0, 0, 4);
    setpx(0, 16, 32, 1, 0, 0, 5);
    setpx(0, 16, 32, 0, 1, 0, 6);
    setpx(0, 16, 32, 1, 1, 0, 7);
    setpx(0, 16, 32, 0, 0, 1, -1);
    setpx(0, 16, 32, 1, 0, 1, -2);
    setpx(0, 16, 32, 0, 1, 1, -2);
    setpx(0, 16, 32, 1, 1, 1, -2);
    gen(0, 16, 16, 32, 2, 0, 1, 1024);
    t = exp_a[0];
    chk("model_avg5", t[15:0], 5);
    chk("model_avgm2", t[31:16], 16'hfffe);
    send(0, 16, 32, 1'b1, 50, 1023, 1024);
    drain(0);
    chk("err_f2", err_a, 0);

    // Frame 3: early eop at beat 100
    fill(0, 16, 16, 32, 2);
    gen(0, 16, 16, 32, 2, 0, 0, 101);
    chk("model_early_cnt", exp_a.size(), 17);
    send(0, 16, 32, 1'b0, -1, 100, 101);
    drain(0);
    chk("err_early", err_a, 1);

    // Frame 4: clean frame after the error
    fill(0, 16, 16, 32, 2);
    gen(0, 16, 16, 32, 2, 0, 0, 1024);
    send(0, 16, 32, 1'b0, -1, 1023, 1024);
    drain(0);
    chk("err_sticky", err_a, 1);

    // 5x5 ReLU instance: partial frame, reset, clean frame
    fill(1, 5, 5, 8, 2);
    gen(1, 5, 5, 8, 2, 1, 0, 12);
    chk("model_b_part", exp_b.size(), 2);
    send(1, 5, 8, 1'b0, -1, -1, 12);
    drain(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_b_rdy", rdy_b, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("err_cleared", err_a, 0);

    fill(1, 5, 5, 8, 2);
    setpx(1, 5, 8, 0, 0, 0, -8);
    setpx(1, 5, 8, 1, 0, 0, -3);
    setpx(1, 5, 8, 0, 1, 0, -5);
    setpx(1, 5, 8, 1, 1, 0, -9);
    setpx(1, 5, 8, 0, 0, 1, 3);
    setpx(1, 5, 8, 1, 0, 1, 1);
    setpx(1, 5, 8, 0, 1, 1, 2);
    setpx(1, 5, 8, 1, 1, 1, 0);
    gen(1, 5, 5, 8, 2, 1, 0, 25);
    chk("model_b_cnt", exp_b.size(), 4);
    t = exp_b[0];
    chk("model_relu0", t[15:0], 0);
    chk("model_relu3", t[31:16], 3);
    t = exp_b[3];
    chk("model_b_eop", t[BW], 1);
    send(1, 5, 8, 1'b0, -1, 24, 25);
    drain(1);
    chk("err_b", err_b, 0);

    repeat (3) @(negedge clk);
    finish_now();
  end

endmodule
